// File: rtl/ping_scheduler.sv
// Sonar ping sequencer: BURST -> BLANK -> LISTEN -> REPORT -> HOLDOFF, with
// emission-time counter, first-echo time-of-flight capture and beam steering.
module ping_scheduler #(
  parameter int BURST_CYCLES   = 20000,
  parameter int BLANK_CYCLES   = 50000,
  parameter int LISTEN_CYCLES  = 2500000,
  parameter int HOLDOFF_CYCLES = 1000000,
  parameter int NUM_STEPS      = 8,
  parameter int CNT_W          = 24,
  localparam int STEER_W       = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic               enable_in,
  input  logic               echo_detected_in,
  output logic               burst_active_out,
  output logic               burst_start_out,
  output logic               listen_active_out,
  output logic [STEER_W-1:0] steer_idx_out,
  output logic [CNT_W-1:0]   time_since_emission_out,
  output logic [CNT_W-1:0]   tof_cycles_out,
  output logic [STEER_W-1:0] result_steer_out,
  output logic               valid_out,
  output logic               no_echo_out,
  output logic               busy_out
);

  localparam int HOLD_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

  localparam logic [CNT_W-1:0]   BURST_LAST  = CNT_W'(BURST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   BLANK_LAST  = CNT_W'(BURST_CYCLES + BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0]   LISTEN_LAST = CNT_W'(BURST_CYCLES + BLANK_CYCLES + LISTEN_CYCLES - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST   = HOLD_W'(HOLDOFF_CYCLES - 1);
  localparam logic [STEER_W-1:0] STEER_LAST  = STEER_W'(NUM_STEPS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BURST,
    S_BLANK,
    S_LISTEN,
    S_REPORT,
    S_HOLDOFF
  } state_t;

  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [HOLD_W-1:0]    hold_cnt_reg;
  logic [CNT_W-1:0]     tof_reg;
  logic [STEER_W-1:0]   steer_reg;
  logic [STEER_W-1:0]   result_steer_reg;
  logic                 no_echo_reg;

  // State register
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; phase boundaries come from the emission counter
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (enable_in) state_next = S_BURST;
      end
      S_BURST: begin
        if (cnt_reg == BURST_LAST) state_next = (BLANK_CYCLES == 0) ? S_LISTEN : S_BLANK;
      end
      S_BLANK: begin
        if (cnt_reg == BLANK_LAST) state_next = S_LISTEN;
      end
      S_LISTEN: begin
        if (echo_detected_in || (cnt_reg == LISTEN_LAST)) state_next = S_REPORT;
      end
      S_REPORT: begin
        if (HOLDOFF_CYCLES == 0) state_next = enable_in ? S_BURST : S_IDLE;
        else                     state_next = S_HOLDOFF;
      end
      S_HOLDOFF: begin
        if (hold_cnt_reg == HOLD_LAST) state_next = enable_in ? S_BURST : S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    burst_active_out  = 1'b0;
    burst_start_out   = 1'b0;
    listen_active_out = 1'b0;
    valid_out         = 1'b0;
    no_echo_out       = 1'b0;
    busy_out          = 1'b1;
    case (state_reg)
      S_IDLE:   busy_out = 1'b0;
      S_BURST: begin
        burst_active_out = 1'b1;
        burst_start_out  = (cnt_reg == '0);
      end
      S_LISTEN: listen_active_out = 1'b1;
      S_REPORT: begin
        valid_out   = 1'b1;
        no_echo_out = no_echo_reg;
      end
      default: ;
    endcase
  end

  // Counter restarts at 0 in the first BURST cycle and reads 0 while idle
  always_comb begin
    cnt_next = (cnt_reg == '1) ? cnt_reg : cnt_reg + CNT_W'(1);
    if ((state_next == S_IDLE) || ((state_next == S_BURST) && (state_reg != S_BURST))) begin
      cnt_next = '0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg          <= '0;
      hold_cnt_reg     <= '0;
      tof_reg          <= '0;
      result_steer_reg <= '0;
      no_echo_reg      <= 1'b0;
      steer_reg        <= '0;
    end else begin
      cnt_reg      <= cnt_next;
      hold_cnt_reg <= (state_reg == S_HOLDOFF) ? hold_cnt_reg + HOLD_W'(1) : '0;
      // Echo wins over timeout on the last listen cycle
      if ((state_reg == S_LISTEN) && (state_next == S_REPORT)) begin
        tof_reg          <= echo_detected_in ? cnt_reg : '0;
        no_echo_reg      <= ~echo_detected_in;
        result_steer_reg <= steer_reg;
      end
      if (state_reg == S_REPORT) begin
        steer_reg <= (steer_reg == STEER_LAST) ? '0 : steer_reg + STEER_W'(1);
      end
    end
  end

  assign steer_idx_out           = steer_reg;
  assign time_since_emission_out = cnt_reg;
  assign tof_cycles_out          = tof_reg;
  assign result_steer_out        = result_steer_reg;

endmodule

// File: tb/tb_ping_scheduler.sv
// Scoreboard bench for ping_scheduler: directed pings push expected reports,
// a negedge monitor pops and compares every valid_out pulse.
module tb_ping_scheduler;

  localparam int BURST   = 4;
  localparam int BLANK   = 3;
  localparam int LISTEN  = 10;
  localparam int HOLDOFF = 2;
  localparam int NSTEPS  = 3;
  localparam int CW      = 8;

  logic          clk_in = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable_in = 1'b0;
  logic          echo_detected_in = 1'b0;
  logic          burst_active_out, burst_start_out, listen_active_out;
  logic [1:0]    steer_idx_out, result_steer_out;
  logic [CW-1:0] time_since_emission_out, tof_cycles_out;
  logic          valid_out, no_echo_out, busy_out;

  ping_scheduler #(
    .BURST_CYCLES(BURST), .BLANK_CYCLES(BLANK), .LISTEN_CYCLES(LISTEN),
    .HOLDOFF_CYCLES(HOLDOFF), .NUM_STEPS(NSTEPS), .CNT_W(CW)
  ) dut (
    .clk_in(clk_in), .rst_n(rst_n), .enable_in(enable_in),
    .echo_detected_in(echo_detected_in),
    .burst_active_out(burst_active_out), .burst_start_out(burst_start_out),
    .listen_active_out(listen_active_out), .steer_idx_out(steer_idx_out),
    .time_since_emission_out(time_since_emission_out),
    .tof_cycles_out(tof_cycles_out), .result_steer_out(result_steer_out),
    .valid_out(valid_out), .no_echo_out(no_echo_out), .busy_out(busy_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [CW-1:0] tof;
    logic          no_echo;
    logic [1:0]    rs;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   total = 0;
  int   passed = 0;
  int   echo_lo = 1;
  int   echo_hi = 0;

  int   tr_nstart, tr_nburst, tr_burst_lo, tr_burst_hi;
  int   tr_listen_lo, tr_listen_hi, tr_nbusy, tr_bad_noecho;
  int   tr_done;
  int   tr_starts[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Monitor: every report is compared against the oldest expected entry
  initial begin
    forever begin
      @(negedge clk_in);
      if (valid_out) begin
        if (sb_q.size() == 0) begin
          check("unexpected_valid", 32'(valid_out), 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          $display("report: tof=%0d no_echo=%0b result_steer=%0d (exp tof=%0d no_echo=%0b steer=%0d)",
                   tof_cycles_out, no_echo_out, result_steer_out, mon_e.tof, mon_e.no_echo, mon_e.rs);
          check("tof", 32'(tof_cycles_out), 32'(mon_e.tof));
          check("no_echo", 32'(no_echo_out), 32'(mon_e.no_echo));
          check("result_steer", 32'(result_steer_out), 32'(mon_e.rs));
        end
      end
    end
  end

  // Echo source: high while busy and the emission count lies in [echo_lo, echo_hi]
  initial begin
    forever begin
      @(negedge clk_in);
      echo_detected_in = busy_out && (int'(time_since_emission_out) >= echo_lo)
                                  && (int'(time_since_emission_out) <= echo_hi);
    end
  end

  // Follow the DUT from the start request until it returns to IDLE
  task automatic trace(input int drop_n, input int drop_cnt);
    int c;
    bit started;
    tr_nstart = 0; tr_nburst = 0; tr_nbusy = 0; tr_bad_noecho = 0; tr_done = 0;
    tr_burst_lo = 999; tr_burst_hi = -1; tr_listen_lo = 999; tr_listen_hi = -1;
    tr_starts.delete();
    started = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_in);
      c = int'(time_since_emission_out);
      if (busy_out) started = 1'b1;
      if (started && !busy_out) begin
        tr_done = 1;
        break;
      end
      if (busy_out) tr_nbusy++;
      if (burst_start_out) begin
        tr_nstart++;
        tr_starts.push_back(i);
      end
      if (burst_active_out) begin
        tr_nburst++;
        if (c < tr_burst_lo) tr_burst_lo = c;
        if (c > tr_burst_hi) tr_burst_hi = c;
      end
      if (listen_active_out) begin
        if (c < tr_listen_lo) tr_listen_lo = c;
        if (c > tr_listen_hi) tr_listen_hi = c;
      end
      if (no_echo_out && !valid_out) tr_bad_noecho++;
      if (burst_active_out && (tr_nstart == drop_n) && (c == drop_cnt)) enable_in = 1'b0;
    end
  endtask

  task automatic run_ping(input string tag, input int lo, input int hi,
                          input int drop_n, input int drop_cnt,
                          input int nstart, input int listen_lo, input int listen_hi,
                          input int nbusy, input int steer_after);
    echo_lo = lo;
    echo_hi = hi;
    enable_in = 1'b1;
    trace(drop_n, drop_cnt);
    $display("%s: starts=%0d burst=%0d..%0d listen=%0d..%0d busy_cycles=%0d steer=%0d",
             tag, tr_nstart, tr_burst_lo, tr_burst_hi, tr_listen_lo, tr_listen_hi, tr_nbusy, steer_idx_out);
    check({tag, "_done"}, 32'(tr_done), 32'd1);
    check({tag, "_nstart"}, 32'(tr_nstart), 32'(nstart));
    check({tag, "_nburst"}, 32'(tr_nburst), 32'(nstart * BURST));
    check({tag, "_burst_lo"}, 32'(tr_burst_lo), 32'd0);
    check({tag, "_burst_hi"}, 32'(tr_burst_hi), 32'(BURST - 1));
    check({tag, "_listen_lo"}, 32'(tr_listen_lo), 32'(listen_lo));
    check({tag, "_listen_hi"}, 32'(tr_listen_hi), 32'(listen_hi));
    check({tag, "_nbusy"}, 32'(tr_nbusy), 32'(nbusy));
    check({tag, "_noecho_outside_valid"}, 32'(tr_bad_noecho), 32'd0);
    check({tag, "_steer_after"}, 32'(steer_idx_out), 32'(steer_after));
    check({tag, "_idle_count"}, 32'(time_since_emission_out), 32'd0);
  endtask

  task automatic check_no_restart(input string tag);
    int n;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_in);
      if (busy_out || burst_start_out) n++;
    end
    check({tag, "_no_restart"}, 32'(n), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hit;
    // Power-on reset
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check("por_busy", 32'(busy_out), 32'd0);
    check("por_steer", 32'(steer_idx_out), 32'd0);
    check("por_time", 32'(time_since_emission_out), 32'd0);
    check("por_valid", 32'(valid_out), 32'd0);
    rst_n = 1'b1;
    @(negedge clk_in);
    check("idle_after_release", 32'(busy_out), 32'd0);

    // Single pings: echo from 9, echo only during blanking, echo on last/first listen cycle
    sb_q.push_back('{tof: 8'd9, no_echo: 1'b0, rs: 2'd0});
    run_ping("echo9", 9, 255, 1, 0, 1, 7, 9, 13, 1);
    sb_q.push_back('{tof: 8'd0, no_echo: 1'b1, rs: 2'd1});
    run_ping("blanked", 0, 6, 1, 0, 1, 7, 16, 20, 2);
    sb_q.push_back('{tof: 8'd16, no_echo: 1'b0, rs: 2'd2});
    run_ping("echo_last", 16, 16, 1, 0, 1, 7, 16, 20, 0);
    sb_q.push_back('{tof: 8'd7, no_echo: 1'b0, rs: 2'd0});
    run_ping("echo_first", 7, 7, 1, 0, 1, 7, 7, 11, 1);

    // Asynchronous reset in the middle of LISTEN
    echo_lo = 1; echo_hi = 0;
    enable_in = 1'b1;
    hit = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_in);
      if (burst_start_out) enable_in = 1'b0;
      if (listen_active_out && (time_since_emission_out == 8'd10)) begin
        hit = 1;
        break;
      end
    end
    check("rst_reached_listen", 32'(hit), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    $display("async reset: listen=%0b time=%0d steer=%0d tof=%0d busy=%0b",
             listen_active_out, time_since_emission_out, steer_idx_out, tof_cycles_out, busy_out);
    check("rst_listen", 32'(listen_active_out), 32'd0);
    check("rst_time", 32'(time_since_emission_out), 32'd0);
    check("rst_steer", 32'(steer_idx_out), 32'd0);
    check("rst_tof", 32'(tof_cycles_out), 32'd0);
    check("rst_busy", 32'(busy_out), 32'd0);
    repeat (2) @(negedge clk_in);
    rst_n = 1'b1;
    @(negedge clk_in);
    check("rst_idle_busy", 32'(busy_out), 32'd0);
    check("rst_idle_steer", 32'(steer_idx_out), 32'd0);

    // Continuous sweep of four pings, enable dropped in the fourth burst
    for (int k = 0; k < 4; k++) sb_q.push_back('{tof: 8'd0, no_echo: 1'b1, rs: 2'(k % NSTEPS)});
    run_ping("sweep", 1, 0, 4, 0, 4, 7, 16, 80, 1);
    for (int k = 0; k + 1 < tr_starts.size(); k++) begin
      check("sweep_start_gap", 32'(tr_starts[k+1] - tr_starts[k]), 32'd20);
    end
    check_no_restart("sweep");

    // Enable dropped a few cycles into BURST
    sb_q.push_back('{tof: 8'd0, no_echo: 1'b1, rs: 2'd1});
    run_ping("drop_in_burst", 1, 0, 1, 2, 1, 7, 16, 20, 2);
    check_no_restart("drop_in_burst");

    repeat (5) @(negedge clk_in);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
